// File: rtl/id_stage_pipe_if.sv
// Signal bundle of the pipelined decode stage: IF/ID inputs, MEM/WB forwarding
// sources, the stall request and the registered ID/EX outputs.
interface id_stage_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 8
);
   logic              id_valid;
   logic [31:0]       id_instr;
   logic [DATA_W-1:0] id_pc_next;
   logic [1:0]        id_regdst;
   logic              id_regwr;
   logic              id_memrd;
   logic              id_memwr;
   logic              id_alusrc1;
   logic              id_alusrc2;
   logic              id_extop;
   logic              id_luop;
   logic [CTRL_W-1:0] id_ctrl;
   logic              flush;
   logic              mem_regwr;
   logic [REG_AW-1:0] mem_dst;
   logic [DATA_W-1:0] mem_data;
   logic              wb_regwr;
   logic [REG_AW-1:0] wb_dst;
   logic [DATA_W-1:0] wb_data;
   logic              stall;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_alu_in1;
   logic [DATA_W-1:0] ex_alu_in2;
   logic [DATA_W-1:0] ex_busb;
   logic [DATA_W-1:0] ex_conba;
   logic [REG_AW-1:0] ex_dst;
   logic              ex_regwr;
   logic              ex_memrd;
   logic              ex_memwr;
   logic [CTRL_W-1:0] ex_ctrl;

   modport slave (
      input  id_valid, id_instr, id_pc_next, id_regdst, id_regwr, id_memrd, id_memwr,
             id_alusrc1, id_alusrc2, id_extop, id_luop, id_ctrl, flush,
             mem_regwr, mem_dst, mem_data, wb_regwr, wb_dst, wb_data,
      output stall, ex_valid, ex_alu_in1, ex_alu_in2, ex_busb, ex_conba, ex_dst,
             ex_regwr, ex_memrd, ex_memwr, ex_ctrl
   );

   modport master (
      output id_valid, id_instr, id_pc_next, id_regdst, id_regwr, id_memrd, id_memwr,
             id_alusrc1, id_alusrc2, id_extop, id_luop, id_ctrl, flush,
             mem_regwr, mem_dst, mem_data, wb_regwr, wb_dst, wb_data,
      input  stall, ex_valid, ex_alu_in1, ex_alu_in2, ex_busb, ex_conba, ex_dst,
             ex_regwr, ex_memrd, ex_memwr, ex_ctrl
   );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined decode/register-read stage: register file, MEM/WB operand forwarding,
// one-bubble RAW stall against EX, and the ID/EX pipeline register.
module id_stage_pipe #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int REG_AW = 5,
   parameter int RA_REG = 31,
   parameter int XP_REG = 26,
   parameter int CTRL_W = 8
) (
   input logic            clk,
   input logic            reset,
   id_stage_pipe_if.slave bus
);
   logic [DATA_W-1:0] regs [NREG];
   logic [REG_AW-1:0] rs, rt, rd, dst;
   logic [4:0]        shamt;
   logic [15:0]       imm16;
   logic [5:0]        opcode_unused;
   logic [DATA_W-1:0] rs_val, rt_val, imm32, alu_in1, alu_in2, conba;
   logic              use_rs, use_rt, hz, load;

   assign opcode_unused = bus.id_instr[31:26];
   assign rs    = REG_AW'(bus.id_instr[25:21]);
   assign rt    = REG_AW'(bus.id_instr[20:16]);
   assign rd    = REG_AW'(bus.id_instr[15:11]);
   assign shamt = bus.id_instr[10:6];
   assign imm16 = bus.id_instr[15:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (bus.wb_regwr && bus.wb_dst != '0) begin
         regs[bus.wb_dst] <= bus.wb_data;
      end
   end

   // MEM beats WB; the WB path doubles as regfile write-through.
   always_comb begin
      if (rs == '0)                                  rs_val = '0;
      else if (bus.mem_regwr && bus.mem_dst == rs)   rs_val = bus.mem_data;
      else if (bus.wb_regwr && bus.wb_dst == rs)     rs_val = bus.wb_data;
      else                                           rs_val = regs[rs];
   end

   always_comb begin
      if (rt == '0)                                  rt_val = '0;
      else if (bus.mem_regwr && bus.mem_dst == rt)   rt_val = bus.mem_data;
      else if (bus.wb_regwr && bus.wb_dst == rt)     rt_val = bus.wb_data;
      else                                           rt_val = regs[rt];
   end

   assign use_rs = ~bus.id_alusrc1;
   assign use_rt = ~bus.id_alusrc2 | bus.id_memwr;

   // EX results are not forwarded, so any live EX writer of a used source costs a bubble.
   assign hz = bus.id_valid & bus.ex_valid & bus.ex_regwr & (bus.ex_dst != '0) &
               ((use_rs & (bus.ex_dst == rs)) | (use_rt & (bus.ex_dst == rt)));
   assign bus.stall = hz & ~bus.flush;
   assign load      = bus.id_valid & ~hz & ~bus.flush;

   always_comb begin
      case (bus.id_regdst)
         2'd0:    dst = rd;
         2'd1:    dst = rt;
         2'd2:    dst = REG_AW'(RA_REG);
         default: dst = REG_AW'(XP_REG);
      endcase
   end

   assign imm32   = bus.id_extop ? DATA_W'($signed(imm16)) : DATA_W'(imm16);
   assign alu_in1 = bus.id_alusrc1 ? DATA_W'(shamt) : rs_val;
   assign alu_in2 = !bus.id_alusrc2 ? rt_val :
                    bus.id_luop     ? DATA_W'({imm16, 16'h0000}) : imm32;
   assign conba   = bus.id_pc_next + DATA_W'($signed({imm16, 2'b00}));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.ex_valid   <= 1'b0;
         bus.ex_regwr   <= 1'b0;
         bus.ex_memrd   <= 1'b0;
         bus.ex_memwr   <= 1'b0;
         bus.ex_alu_in1 <= '0;
         bus.ex_alu_in2 <= '0;
         bus.ex_busb    <= '0;
         bus.ex_conba   <= '0;
         bus.ex_dst     <= '0;
         bus.ex_ctrl    <= '0;
      end else begin
         bus.ex_valid <= load;
         bus.ex_regwr <= load & bus.id_regwr;
         bus.ex_memrd <= load & bus.id_memrd;
         bus.ex_memwr <= load & bus.id_memwr;
         if (load) begin
            bus.ex_alu_in1 <= alu_in1;
            bus.ex_alu_in2 <= alu_in2;
            bus.ex_busb    <= rt_val;
            bus.ex_conba   <= conba;
            bus.ex_dst     <= dst;
            bus.ex_ctrl    <= bus.id_ctrl;
         end
      end
   end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed vector table, hand-written
// multi-cycle corner cases, then random stimulus against a reference model.
module tb_id_stage_pipe;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   id_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) bus ();

   id_stage_pipe #(.DATA_W(DW), .NREG(32), .REG_AW(AW), .RA_REG(31), .XP_REG(26), .CTRL_W(CW))
      dut (.clk(clk), .reset(reset), .bus(bus.slave));

   int total = 0;
   int bad = 0;

   // reference model state
   logic [31:0] mreg [32];
   logic        m_valid, m_regwr, m_memrd, m_memwr;
   logic [4:0]  m_dst;
   logic [31:0] m_in1, m_in2, m_busb, m_conba;
   logic [7:0]  m_ctrl;
   logic        e_stall;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [1:0]  regdst;
      logic        a1, a2, ext, lu, memwr;
      logic        mwr;
      logic [4:0]  mdst;
      logic [31:0] mdata;
      logic        wwr;
      logic [4:0]  wdst;
      logic [31:0] wdata;
      logic [31:0] e_in1, e_in2, e_busb, e_conba;
      logic [4:0]  e_dst;
   } vec_t;
   vec_t vt [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] s, t, d, sh);
      return {6'h00, s, t, d, sh, 6'h00};
   endfunction

   function automatic logic [31:0] itype(input logic [4:0] s, t, input logic [15:0] imm);
      return {6'h08, s, t, imm};
   endfunction

   task automatic clear_in();
      bus.id_valid = 1'b0; bus.id_instr = '0; bus.id_pc_next = '0; bus.id_regdst = '0;
      bus.id_regwr = 1'b0; bus.id_memrd = 1'b0; bus.id_memwr = 1'b0;
      bus.id_alusrc1 = 1'b0; bus.id_alusrc2 = 1'b0; bus.id_extop = 1'b0; bus.id_luop = 1'b0;
      bus.id_ctrl = '0; bus.flush = 1'b0;
      bus.mem_regwr = 1'b0; bus.mem_dst = '0; bus.mem_data = '0;
      bus.wb_regwr = 1'b0; bus.wb_dst = '0; bus.wb_data = '0;
   endtask

   task automatic id_set(input logic [31:0] instr, input logic [1:0] regdst,
                         input logic regwr, a1, a2, lu);
      clear_in();
      bus.id_valid = 1'b1; bus.id_instr = instr; bus.id_regdst = regdst;
      bus.id_regwr = regwr; bus.id_alusrc1 = a1; bus.id_alusrc2 = a2; bus.id_luop = lu;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ex(input string tag);
      chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(m_valid));
      chk({tag, ".regwr"}, 32'(bus.ex_regwr), 32'(m_regwr));
      chk({tag, ".memrd"}, 32'(bus.ex_memrd), 32'(m_memrd));
      chk({tag, ".memwr"}, 32'(bus.ex_memwr), 32'(m_memwr));
      if (m_valid) begin
         chk({tag, ".in1"},   bus.ex_alu_in1, m_in1);
         chk({tag, ".in2"},   bus.ex_alu_in2, m_in2);
         chk({tag, ".busb"},  bus.ex_busb, m_busb);
         chk({tag, ".conba"}, bus.ex_conba, m_conba);
         chk({tag, ".dst"},   32'(bus.ex_dst), 32'(m_dst));
         chk({tag, ".ctrl"},  32'(bus.ex_ctrl), 32'(m_ctrl));
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (bus.mem_regwr && bus.mem_dst == r) return bus.mem_data;
      if (bus.wb_regwr && bus.wb_dst == r) return bus.wb_data;
      return mreg[r];
   endfunction

   // Expected stall now and expected ID/EX contents after the next edge.
   task automatic model_eval();
      logic [4:0]  s, t, d;
      logic [15:0] imm;
      logic        use_s, use_t, dep;
      int          simm;
      s = bus.id_instr[25:21];
      t = bus.id_instr[20:16];
      d = bus.id_instr[15:11];
      imm = bus.id_instr[15:0];
      simm = $signed(imm);
      use_s = !bus.id_alusrc1;
      use_t = !bus.id_alusrc2 || bus.id_memwr;
      dep = bus.id_valid && m_valid && m_regwr && m_dst != 5'd0 &&
            ((use_s && m_dst == s) || (use_t && m_dst == t));
      e_stall = dep && !bus.flush;
      if (bus.flush || dep || !bus.id_valid) begin
         m_valid = 1'b0; m_regwr = 1'b0; m_memrd = 1'b0; m_memwr = 1'b0;
      end else begin
         m_valid = 1'b1;
         m_regwr = bus.id_regwr; m_memrd = bus.id_memrd; m_memwr = bus.id_memwr;
         m_in1 = bus.id_alusrc1 ? 32'(bus.id_instr[10:6]) : ref_read(s);
         if (!bus.id_alusrc2)  m_in2 = ref_read(t);
         else if (bus.id_luop) m_in2 = 32'(int'(imm) * 65536);
         else if (bus.id_extop) m_in2 = 32'(simm);
         else                  m_in2 = 32'(int'(imm));
         m_busb  = ref_read(t);
         m_conba = bus.id_pc_next + 32'(simm * 4);
         case (bus.id_regdst)
            2'd0:    m_dst = d;
            2'd1:    m_dst = t;
            2'd2:    m_dst = 5'd31;
            default: m_dst = 5'd26;
         endcase
         m_ctrl = bus.id_ctrl;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      //                instr                        pc          rd   a1   a2   ext  lu   mw   mwr  mdst   mdata          wwr  wdst   wdata          in1            in2            busb           conba          dst
      vt[0]  = '{rtype(5'd5,5'd0,5'd1,5'd0),  32'h1000,  2'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       32'h1234,     32'h0,        32'h0,        32'h3000,     5'd1};
      vt[1]  = '{rtype(5'd3,5'd3,5'd6,5'd0),  32'h2000,  2'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,5'd3,32'hAAAA,    1'b1,5'd3,32'hBBBB,    32'hAAAA,     32'hAAAA,     32'hAAAA,     32'hE000,     5'd6};
      vt[2]  = '{rtype(5'd3,5'd3,5'd6,5'd0),  32'h2000,  2'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd3,32'hAAAA,    1'b1,5'd3,32'hBBBB,    32'hBBBB,     32'hBBBB,     32'hBBBB,     32'hE000,     5'd6};
      vt[3]  = '{rtype(5'd3,5'd3,5'd6,5'd0),  32'h0,     2'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,5'd7,32'h5555,    1'b0,5'd0,32'h0,       32'hBBBB,     32'hBBBB,     32'hBBBB,     32'hC000,     5'd6};
      vt[4]  = '{itype(5'd1,5'd2,16'hFFFE),   32'h100,   2'd1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       32'h11,       32'h0000FFFE, 32'h22,       32'hF8,       5'd2};
      vt[5]  = '{itype(5'd1,5'd2,16'hFFFE),   32'h100,   2'd1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       32'h11,       32'hFFFFFFFE, 32'h22,       32'hF8,       5'd2};
      vt[6]  = '{itype(5'd0,5'd2,16'h8000),   32'h40000, 2'd1,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       32'h0,        32'h80000000, 32'h22,       32'h20000,    5'd2};
      vt[7]  = '{rtype(5'd0,5'd2,5'd4,5'd7),  32'h0,     2'd0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       32'h7,        32'h22,       32'h22,       32'h8700,     5'd4};
      vt[8]  = '{rtype(5'd1,5'd2,5'd4,5'd0),  32'h0,     2'd2,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       32'h11,       32'h22,       32'h22,       32'h8000,     5'd31};
      vt[9]  = '{rtype(5'd1,5'd2,5'd4,5'd0),  32'h0,     2'd3,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       32'h11,       32'h22,       32'h22,       32'h8000,     5'd26};
      vt[10] = '{rtype(5'd0,5'd0,5'd1,5'd0),  32'h0,     2'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,5'd0,32'hDEAD,    1'b1,5'd0,32'hBEEF,    32'h0,        32'h0,        32'h0,        32'h2000,     5'd1};
      vt[11] = '{itype(5'd5,5'd0,16'h0004),   32'h0,     2'd1,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       32'h1234,     32'h4,        32'h0,        32'h10,       5'd0};

      // reset: asynchronous clear, no stall, nothing issues while held
      clear_in();
      #2 reset = 1'b0;
      #1;
      bus.id_valid = 1'b1; bus.id_instr = rtype(5'd1, 5'd2, 5'd3, 5'd0); bus.id_regwr = 1'b1;
      #1;
      chk("rst.stall", 32'(bus.stall), 32'h0);
      tick();
      m_valid = 1'b0; m_regwr = 1'b0; m_memrd = 1'b0; m_memwr = 1'b0;
      check_ex("rst");
      chk("rst.in1", bus.ex_alu_in1, 32'h0);
      chk("rst.conba", bus.ex_conba, 32'h0);
      reset = 1'b1;

      // preload r5, r0 (ignored), r1, r2 through WB
      clear_in(); bus.wb_regwr = 1'b1; bus.wb_dst = 5'd5; bus.wb_data = 32'h1234; tick();
      bus.wb_dst = 5'd0; bus.wb_data = 32'hFFFF; tick();
      bus.wb_dst = 5'd1; bus.wb_data = 32'h11;   tick();
      bus.wb_dst = 5'd2; bus.wb_data = 32'h22;   tick();

      for (int i = 0; i < 12; i++) begin
         clear_in();
         bus.id_valid = 1'b1; bus.id_instr = vt[i].instr; bus.id_pc_next = vt[i].pc;
         bus.id_regdst = vt[i].regdst; bus.id_alusrc1 = vt[i].a1; bus.id_alusrc2 = vt[i].a2;
         bus.id_extop = vt[i].ext; bus.id_luop = vt[i].lu; bus.id_memwr = vt[i].memwr;
         bus.id_memrd = i[0]; bus.id_ctrl = 8'(i * 17 + 3);
         bus.mem_regwr = vt[i].mwr; bus.mem_dst = vt[i].mdst; bus.mem_data = vt[i].mdata;
         bus.wb_regwr = vt[i].wwr; bus.wb_dst = vt[i].wdst; bus.wb_data = vt[i].wdata;
         #1;
         chk($sformatf("tbl%0d.stall", i), 32'(bus.stall), 32'h0);
         tick();
         m_valid = 1'b1; m_regwr = 1'b0; m_memrd = i[0]; m_memwr = vt[i].memwr;
         m_in1 = vt[i].e_in1; m_in2 = vt[i].e_in2; m_busb = vt[i].e_busb;
         m_conba = vt[i].e_conba; m_dst = vt[i].e_dst; m_ctrl = 8'(i * 17 + 3);
         check_ex($sformatf("tbl%0d", i));
      end

      // load-use: lw r2 in EX, add r4,r2,r1 stalls once, then takes r2 from MEM
      id_set(itype(5'd1, 5'd2, 16'h0), 2'd1, 1'b1, 1'b0, 1'b1, 1'b0); bus.id_memrd = 1'b1;
      tick();
      chk("lu.ld_valid", 32'(bus.ex_valid), 32'h1);
      chk("lu.ld_dst", 32'(bus.ex_dst), 32'd2);
      id_set(rtype(5'd2, 5'd1, 5'd4, 5'd0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("lu.stall", 32'(bus.stall), 32'h1);
      tick();
      chk("lu.bubble_valid", 32'(bus.ex_valid), 32'h0);
      chk("lu.bubble_regwr", 32'(bus.ex_regwr), 32'h0);
      bus.mem_regwr = 1'b1; bus.mem_dst = 5'd2; bus.mem_data = 32'h77;
      #1 chk("lu.stall_done", 32'(bus.stall), 32'h0);
      tick();
      chk("lu.add_valid", 32'(bus.ex_valid), 32'h1);
      chk("lu.add_in1", bus.ex_alu_in1, 32'h77);
      chk("lu.add_in2", bus.ex_alu_in2, 32'h11);

      // unused sources: lui behind a writer of r2, reader of r0 behind a writer of r0
      id_set(itype(5'd1, 5'd2, 16'h0), 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      id_set(itype(5'd0, 5'd2, 16'h8000), 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
      #1 chk("lui.stall", 32'(bus.stall), 32'h0);
      tick();
      chk("lui.valid", 32'(bus.ex_valid), 32'h1);
      chk("lui.in2", bus.ex_alu_in2, 32'h80000000);
      id_set(rtype(5'd1, 5'd1, 5'd0, 5'd0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      id_set(rtype(5'd0, 5'd0, 5'd3, 5'd0), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("r0.stall", 32'(bus.stall), 32'h0);
      tick();
      chk("r0.valid", 32'(bus.ex_valid), 32'h1);

      // flush overrides a pending stall
      id_set(itype(5'd1, 5'd2, 16'h0), 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      id_set(rtype(5'd2, 5'd1, 5'd4, 5'd0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      bus.flush = 1'b1;
      #1 chk("fl.stall", 32'(bus.stall), 32'h0);
      tick();
      chk("fl.valid", 32'(bus.ex_valid), 32'h0);
      chk("fl.regwr", 32'(bus.ex_regwr), 32'h0);

      // reset in the middle of a stall, then the held instruction issues
      id_set(itype(5'd1, 5'd2, 16'h0), 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      id_set(rtype(5'd2, 5'd1, 5'd4, 5'd0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("rs.stall_before", 32'(bus.stall), 32'h1);
      reset = 1'b0;
      #1;
      chk("rs.valid", 32'(bus.ex_valid), 32'h0);
      chk("rs.stall", 32'(bus.stall), 32'h0);
      tick();
      reset = 1'b1;
      #1 chk("rs.stall_after", 32'(bus.stall), 32'h0);
      tick();
      chk("rs.reissue_valid", 32'(bus.ex_valid), 32'h1);
      chk("rs.reissue_in1", bus.ex_alu_in1, 32'h0);
      chk("rs.reissue_dst", 32'(bus.ex_dst), 32'd4);

      // random phase from a clean reset
      clear_in();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
      m_valid = 1'b0; m_regwr = 1'b0; m_memrd = 1'b0; m_memwr = 1'b0;
      for (int n = 0; n < 600; n++) begin
         bus.id_instr = $urandom;
         bus.id_instr[25:21] = 5'($urandom_range(0, 3));
         bus.id_instr[20:16] = 5'($urandom_range(0, 3));
         bus.id_instr[15:11] = 5'($urandom_range(0, 3));
         bus.id_valid   = ($urandom_range(0, 7) != 0);
         bus.flush      = ($urandom_range(0, 7) == 0);
         bus.id_pc_next = $urandom;
         bus.id_regdst  = 2'($urandom);
         bus.id_regwr   = ($urandom_range(0, 3) != 0);
         bus.id_memrd   = 1'($urandom);
         bus.id_memwr   = 1'($urandom);
         bus.id_alusrc1 = 1'($urandom);
         bus.id_alusrc2 = 1'($urandom);
         bus.id_extop   = 1'($urandom);
         bus.id_luop    = 1'($urandom);
         bus.id_ctrl    = 8'($urandom);
         bus.mem_regwr  = 1'($urandom);
         bus.mem_dst    = 5'($urandom_range(0, 3));
         bus.mem_data   = $urandom;
         bus.wb_regwr   = 1'($urandom);
         bus.wb_dst     = 5'($urandom_range(0, 3));
         bus.wb_data    = $urandom;
         model_eval();
         #1 chk($sformatf("rnd%0d.stall", n), 32'(bus.stall), 32'(e_stall));
         tick();
         if (bus.wb_regwr && bus.wb_dst != 5'd0) mreg[bus.wb_dst] = bus.wb_data;
         check_ex($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Pipelined successor to the single-cycle decode/register-read stage.
- Takes an already-fetched instruction plus its decoded control from IF/ID, holds the register file, and resolves operands with MEM/WB forwarding.
- Detects RAW hazards against the instruction in EX and stalls.
- Registers ALU operands, store data, branch target and destination into an ID/EX pipeline register with a valid bit.

Parameters:
DATA_W, 32, datapath width (must be >=32)
NREG, 32, register count (power of 2)
REG_AW, 5, register address width, log2(NREG)
RA_REG, 31, link register index (RegDst=2)
XP_REG, 26, exception register index (RegDst=3)
CTRL_W, 8, opaque control bits carried to EX unchanged

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_instr  in  32  instruction word
id_pc_next  in  DATA_W  PC+4 of that instruction
id_regdst  in  2  0=rd 1=rt 2=RA_REG 3=XP_REG
id_regwr, id_memrd, id_memwr  in  1 each  decoded control
id_alusrc1  in  1  0=rs 1=shamt
id_alusrc2  in  1  0=rt 1=immediate
id_extop  in  1  1=sign-extend imm16
id_luop  in  1  1=imm16 in bits[31:16]
id_ctrl  in  CTRL_W  pass-through control
flush  in  1  kill the ID instruction
mem_regwr  in  1  MEM-stage write enable
mem_dst  in  REG_AW  MEM-stage destination
mem_data  in  DATA_W  MEM-stage final result
wb_regwr  in  1  WB write enable
wb_dst  in  REG_AW  WB destination
wb_data  in  DATA_W  WB data
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  ID/EX valid
ex_alu_in1, ex_alu_in2  out  DATA_W  ALU operands
ex_busb  out  DATA_W  forwarded rt value (store data)
ex_conba  out  DATA_W  branch target
ex_dst  out  REG_AW  resolved destination
ex_regwr, ex_memrd, ex_memwr  out  1 each  registered control
ex_ctrl  out  CTRL_W  registered pass-through

Behaviour:
- Reset (reset=0, asynchronous):
  - All ID/EX outputs go to 0.
  - All NREG registers go to 0.
  - stall=0 while in reset.
- Register file:
  - Written on clk rise when wb_regwr=1 and wb_dst!=0.
  - Register 0 always reads 0.
- Operand resolution, per source (rs, rt), in priority order:
  - src==0: value is 0.
  - mem_regwr=1 and mem_dst==src: mem_data.
  - wb_regwr=1 and wb_dst==src: wb_data (write-through).
  - Otherwise: the regfile value.
- Source usage:
  - rs is used iff id_alusrc1=0.
  - rt is used iff id_alusrc2=0 or id_memwr=1.
- Hazard:
  - hz = id_valid and ex_valid and ex_regwr and ex_dst!=0 and (ex_dst matches a used source).
  - The EX result is not forwarded to ID, so any match (load or ALU) costs one bubble.
  - stall = hz and not flush.
- Destination: rd, rt, RA_REG or XP_REG, selected by id_regdst.
- Immediate: imm32 = imm16 sign- or zero-extended to DATA_W per id_extop.
- ALU operands:
  - alu_in1 = rs value, or zero-extended shamt (instr[10:6]).
  - alu_in2 = rt value, or imm16 shifted left 16 (if id_luop), else imm32.
- Branch target: conba = id_pc_next + (sign-extended imm16 << 2), mod 2^DATA_W, independent of id_extop.
- ID/EX update on clk rise:
  - flush=1: ex_valid=0 and ex_regwr/ex_memrd/ex_memwr=0; other fields don't-care. flush has priority over stall.
  - stall=1: bubble. ex_valid and the write/memory controls go to 0. IF/ID holds externally, so the same instruction is re-evaluated next cycle.
  - id_valid=0: bubble, same as stall.
  - Otherwise: all fields load and ex_valid=1.
- A bubble in EX never causes a hazard, so a stall lasts exactly one cycle per dependency.
- Latency: one cycle, ID to EX outputs.
- Reset asserted mid-stall clears ID/EX. The IF/ID contents are re-evaluated after release.

Test Plan:
- Reset then regfile write: wb writes r5=0x1234 and r0=0xFFFF. An `add r1,r5,r0` then gives ex_alu_in1=0x1234, ex_alu_in2=0, ex_dst=1, ex_valid=1 one cycle later.
- Forward priority: mem writes r3=0xAAAA while wb writes r3=0xBBBB in the same cycle. A read of r3 yields 0xAAAA. With mem_regwr=0 it yields 0xBBBB.
- Load-use stall: `lw r2` in EX, `add r4,r2,r1` in ID. stall=1 for one cycle and ex_valid=0 next. Once the load moves to MEM (mem_dst=2, mem_data=0x77), the add issues with alu_in1=0x77.
- Unused source: `lui r2,0x8000` (alusrc1=1, alusrc2=1) behind a writer of r2 and r0. No stall, and ex_alu_in2=0x80000000.
- Branch target and extension: pc_next=0x100, imm16=0xFFFE. ex_conba=0xF8. With extop=0, ex_alu_in2=0x0000FFFE. With extop=1, ex_alu_in2=0xFFFFFFFE.
- Flush during stall: hazard present and flush=1. Then stall=0, ex_valid=0, ex_regwr=0.
